uart_rx_fifo: RTL and testbench

Receive buffer placed directly downstream of the UART receive frontend and upstream of the register/bus block. It captures each received frame, keeping the low 8 data bits and the parity/framing error flags, into a first-word-fall-through queue. The register block pops one entry per UART_RXDR read. The FIFO reports level, a programmable threshold flag and a sticky overrun flag, so software can tolerate bursts without losing bytes.

---
 rtl/uart_rx_fifo.sv | 110 +++++++++++
 tb/tb_uart_rx_fifo.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer between the UART receive frontend and the register block.
// Stores {parity_err, frame_err, data[7:0]} per frame; reports level, threshold and a sticky overrun.
module uart_rx_fifo #(
   parameter int DEPTH          = 16,
   parameter int MAX_FRAME_SIZE = 11,
   localparam int LEVEL_W       = $clog2(DEPTH) + 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      flush_i,
   input  logic [MAX_FRAME_SIZE-1:0] frame_i,
   input  logic                      parity_err_i,
   input  logic                      frame_err_i,
   input  logic                      valid_i,
   input  logic                      pop_i,
   output logic [7:0]                data_o,
   output logic                      parity_err_o,
   output logic                      frame_err_o,
   output logic                      empty_o,
   output logic                      full_o,
   output logic [LEVEL_W-1:0]        level_o,
   input  logic [LEVEL_W-1:0]        threshold_i,
   output logic                      threshold_o,
   output logic                      overrun_o,
   input  logic                      clear_overrun_i
);

   localparam int AW = $clog2(DEPTH);

   // Handshake: valid_i is a one-cycle strobe with no back-pressure (a push into a full
   // FIFO without a coincident pop is dropped and flagged); pop_i is honoured only when not empty.

   logic [9:0]         mem [DEPTH];
   logic [AW:0]        wr_ptr, rd_ptr;
   logic [LEVEL_W-1:0] level_q, level_next;
   logic               empty_q, full_q, threshold_q, overrun_q, overrun_next;
   logic               do_push, do_pop, drop;
   logic [9:0]         head;

   // Only the low 8 frame bits are buffered; the rest are intentionally ignored.
   logic unused_frame_bits;
   assign unused_frame_bits = ^frame_i[MAX_FRAME_SIZE-1:8];

   assign do_pop  = pop_i && !empty_q;
   assign do_push = valid_i && (!full_q || do_pop);
   assign drop    = valid_i && full_q && !do_pop;

   always_comb begin
      level_next = level_q;
      if (flush_i)
         level_next = '0;
      else if (do_push && !do_pop)
         level_next = level_q + LEVEL_W'(1);
      else if (do_pop && !do_push)
         level_next = level_q - LEVEL_W'(1);
   end

   // Set beats clear; flush beats everything.
   always_comb begin
      overrun_next = overrun_q;
      if (flush_i)
         overrun_next = 1'b0;
      else if (drop)
         overrun_next = 1'b1;
      else if (clear_overrun_i)
         overrun_next = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level_q     <= '0;
         empty_q     <= 1'b1;
         full_q      <= 1'b0;
         threshold_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
         end
         level_q     <= level_next;
         empty_q     <= (level_next == '0);
         full_q      <= (level_next == LEVEL_W'(DEPTH));
         threshold_q <= (threshold_i != '0) && (level_next >= threshold_i);
         overrun_q   <= overrun_next;
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i)
         mem[wr_ptr[AW-1:0]] <= {parity_err_i, frame_err_i, frame_i[7:0]};
   end

   assign head         = empty_q ? 10'd0 : mem[rd_ptr[AW-1:0]];
   assign data_o       = head[7:0];
   assign frame_err_o  = head[8];
   assign parity_err_o = head[9];
   assign empty_o      = empty_q;
   assign full_o       = full_q;
   assign level_o      = level_q;
   assign threshold_o  = threshold_q;
   assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at DEPTH=4 with hand-computed expectations.
module tb_uart_rx_fifo;

   localparam int DEPTH = 4;
   localparam int MFS   = 11;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           flush = 1'b0;
   logic [MFS-1:0] frame = '0;
   logic           parity_err = 1'b0;
   logic           frame_err = 1'b0;
   logic           valid = 1'b0;
   logic           pop = 1'b0;
   logic [7:0]     data;
   logic           parity_err_h, frame_err_h;
   logic           empty, full;
   logic [LW-1:0]  level;
   logic [LW-1:0]  threshold = '0;
   logic           thr_flag, overrun;
   logic           clear_overrun = 1'b0;

   int n_cmp  = 0;
   int n_fail = 0;

   uart_rx_fifo #(.DEPTH(DEPTH), .MAX_FRAME_SIZE(MFS)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .frame_i(frame),
      .parity_err_i(parity_err), .frame_err_i(frame_err), .valid_i(valid), .pop_i(pop),
      .data_o(data), .parity_err_o(parity_err_h), .frame_err_o(frame_err_h),
      .empty_o(empty), .full_o(full), .level_o(level), .threshold_i(threshold),
      .threshold_o(thr_flag), .overrun_o(overrun), .clear_overrun_i(clear_overrun)
   );

   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic push_byte(input logic [7:0] b, input logic pe, input logic fe);
      frame = {3'b101, b};
      parity_err = pe;
      frame_err = fe;
      valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      parity_err = 1'b0;
      frame_err = 1'b0;
   endtask

   task automatic pop_one();
      pop = 1'b1;
      @(posedge clk); #1;
      pop = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      n_cmp++;
      if ({empty, full, level, thr_flag, overrun} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_flags: got e=%b f=%b lvl=%0d thr=%b ovr=%b, want e=1 f=0 lvl=0 thr=0 ovr=0",
                  empty, full, level, thr_flag, overrun);
      end
      n_cmp++;
      if ({data, parity_err_h, frame_err_h} !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_head: got data=%h pe=%b fe=%b, want 00/0/0", data, parity_err_h, frame_err_h);
      end
   endtask

   task automatic test_basic();
      pop_one();  // pop on empty must be ignored
      n_cmp++;
      if ({empty, level} !== {1'b1, 3'd0}) begin
         n_fail++;
         $display("FAIL pop_empty: got e=%b lvl=%0d, want e=1 lvl=0", empty, level);
      end
      for (int i = 0; i < 3; i++) begin
         push_byte(8'h41 + 8'(i), 1'b0, 1'b0);
         n_cmp++;
         if ({level, data, empty} !== {3'(i + 1), 8'h41, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_push%0d: got lvl=%0d data=%h e=%b, want lvl=%0d data=41 e=0",
                     i, level, data, empty, i + 1);
         end
         idle(2);
      end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (data !== 8'h41 + 8'(i)) begin
            n_fail++;
            $display("FAIL basic_pop%0d: got %h, want %h", i, data, 8'h41 + 8'(i));
         end
         pop_one();
      end
      n_cmp++;
      if ({empty, data, level} !== {1'b1, 8'h00, 3'd0}) begin
         n_fail++;
         $display("FAIL basic_drained: got e=%b data=%h lvl=%0d, want e=1 data=00 lvl=0", empty, data, level);
      end
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i), 1'b0, 1'b0);
      n_cmp++;
      if ({full, level, overrun} !== {1'b1, 3'd4, 1'b0}) begin
         n_fail++;
         $display("FAIL ovr_full: got f=%b lvl=%0d ovr=%b, want f=1 lvl=4 ovr=0", full, level, overrun);
      end
      push_byte(8'h14, 1'b0, 1'b0);
      n_cmp++;
      if ({full, level, overrun, data} !== {1'b1, 3'd4, 1'b1, 8'h10}) begin
         n_fail++;
         $display("FAIL ovr_drop: got f=%b lvl=%0d ovr=%b data=%h, want f=1 lvl=4 ovr=1 data=10",
                  full, level, overrun, data);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (data !== 8'h10 + 8'(i)) begin
            n_fail++;
            $display("FAIL ovr_pop%0d: got %h, want %h", i, data, 8'h10 + 8'(i));
         end
         pop_one();
      end
      n_cmp++;
      if ({empty, overrun} !== 2'b11) begin
         n_fail++;
         $display("FAIL ovr_sticky: got e=%b ovr=%b, want e=1 ovr=1", empty, overrun);
      end
      clear_overrun = 1'b1;
      idle(1);
      clear_overrun = 1'b0;
      n_cmp++;
      if (overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL ovr_clear: got %b, want 0", overrun);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) push_byte(8'h20 + 8'(i), 1'b0, 1'b0);
      pop = 1'b1;
      push_byte(8'h24, 1'b0, 1'b0);
      pop = 1'b0;
      n_cmp++;
      if ({level, full, overrun, data} !== {3'd4, 1'b1, 1'b0, 8'h21}) begin
         n_fail++;
         $display("FAIL b2b_full: got lvl=%0d f=%b ovr=%b data=%h, want lvl=4 f=1 ovr=0 data=21",
                  level, full, overrun, data);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (data !== 8'h21 + 8'(i)) begin
            n_fail++;
            $display("FAIL b2b_pop%0d: got %h, want %h", i, data, 8'h21 + 8'(i));
         end
         pop_one();
      end
      n_cmp++;
      if (empty !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_empty: got %b, want 1", empty);
      end
   endtask

   task automatic test_flags();
      push_byte(8'h55, 1'b1, 1'b0);
      push_byte(8'h66, 1'b0, 1'b1);
      n_cmp++;
      if ({data, parity_err_h, frame_err_h} !== {8'h55, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL flags_first: got %h/pe=%b/fe=%b, want 55/pe=1/fe=0", data, parity_err_h, frame_err_h);
      end
      pop_one();
      n_cmp++;
      if ({data, parity_err_h, frame_err_h} !== {8'h66, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL flags_second: got %h/pe=%b/fe=%b, want 66/pe=0/fe=1", data, parity_err_h, frame_err_h);
      end
      pop_one();
   endtask

   task automatic test_threshold();
      threshold = 3'd3;
      idle(1);
      for (int i = 1; i <= 3; i++) begin
         push_byte(8'h30 + 8'(i), 1'b0, 1'b0);
         n_cmp++;
         if ({level, thr_flag} !== {3'(i), (i == 3)}) begin
            n_fail++;
            $display("FAIL thr_push%0d: got lvl=%0d thr=%b, want lvl=%0d thr=%b", i, level, thr_flag, i, (i == 3));
         end
      end
      pop_one();
      n_cmp++;
      if ({level, thr_flag} !== {3'd2, 1'b0}) begin
         n_fail++;
         $display("FAIL thr_pop: got lvl=%0d thr=%b, want lvl=2 thr=0", level, thr_flag);
      end
      threshold = 3'd0;
      for (int i = 3; i <= 4; i++) begin
         push_byte(8'h40, 1'b0, 1'b0);
         n_cmp++;
         if ({level, thr_flag} !== {3'(i), 1'b0}) begin
            n_fail++;
            $display("FAIL thr_zero%0d: got lvl=%0d thr=%b, want lvl=%0d thr=0", i, level, thr_flag, i);
         end
      end
      for (int i = 0; i < 4; i++) pop_one();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 4; i++) push_byte(8'h50 + 8'(i), 1'b0, 1'b0);
      clear_overrun = 1'b1;  // set must win over clear
      push_byte(8'hEE, 1'b0, 1'b0);
      clear_overrun = 1'b0;
      n_cmp++;
      if (overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL set_beats_clear: got ovr=%b, want 1", overrun);
      end
      pop_one();
      pop_one();
      flush = 1'b1;
      push_byte(8'h77, 1'b0, 1'b0);
      flush = 1'b0;
      n_cmp++;
      if ({level, empty, overrun, data} !== {3'd0, 1'b1, 1'b0, 8'h00}) begin
         n_fail++;
         $display("FAIL flush: got lvl=%0d e=%b ovr=%b data=%h, want lvl=0 e=1 ovr=0 data=00",
                  level, empty, overrun, data);
      end
      push_byte(8'h78, 1'b0, 1'b0);
      n_cmp++;
      if ({level, data} !== {3'd1, 8'h78}) begin
         n_fail++;
         $display("FAIL post_flush: got lvl=%0d data=%h, want lvl=1 data=78", level, data);
      end
   endtask

   task automatic test_reset_mid();
      threshold = 3'd1;
      push_byte(8'h81, 1'b0, 1'b0);
      push_byte(8'h82, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) push_byte(8'h83, 1'b0, 1'b0);
      #2;
      valid = 1'b1;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({empty, full, level, thr_flag, overrun, data, parity_err_h, frame_err_h} !==
          {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_mid: got e=%b f=%b lvl=%0d thr=%b ovr=%b data=%h, want e=1 f=0 lvl=0 thr=0 ovr=0 data=00",
                  empty, full, level, thr_flag, overrun, data);
      end
      idle(2);
      valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      idle(1);
      push_byte(8'h99, 1'b0, 1'b0);
      n_cmp++;
      if ({level, data, empty, thr_flag} !== {3'd1, 8'h99, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL after_reset: got lvl=%0d data=%h e=%b thr=%b, want lvl=1 data=99 e=0 thr=1",
                  level, data, empty, thr_flag);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      idle(1);
      test_basic();
      test_overrun();
      test_back_to_back();
      test_flags();
      test_threshold();
      test_flush();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
